aes128_key_expand: RTL and testbench



---
 rtl/aes128_key_expand.sv | 145 ++++++++++++++
 tb/tb_aes128_key_expand.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/aes128_key_expand.sv
// ---------------------------------------------------------------------------
// aes128_key_expand
// Iterative AES-128 key schedule. Produces round keys 0..10, one per clock,
// on a valid-qualified output. It also stores every key in a round-key file
// so that the downstream encrypt core can read any round key by index.
//
// Ports
//   clk        in   rising-edge clock
//   reset_n    in   asynchronous active-low reset
//   start      in   expansion request; only accepted while busy=0
//   key        in   [127:0] cipher key, latched on the accepted start
//   busy       out  expansion in progress
//   rk_valid   out  round_key / rk_index valid this cycle
//   rk_index   out  [3:0] round number of round_key
//   round_key  out  [127:0] current round key (key[127:120] is byte 0)
//   done       out  one-cycle pulse together with the last round key
//   rd_index   in   [3:0] round-key file read address
//   rd_key     out  [127:0] combinational file read, 0 past the last round
//
// state  | meaning
// IDLE   | waiting for start; outputs hold the last key and index
// EXPAND | presenting one round key per cycle, rk_index 0..NUM_ROUNDS
// ---------------------------------------------------------------------------
module aes128_key_expand #(
    parameter int NUM_ROUNDS = 10
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [127:0] key,
    output logic         busy,
    output logic         rk_valid,
    output logic [3:0]   rk_index,
    output logic [127:0] round_key,
    output logic         done,
    input  logic [3:0]   rd_index,
    output logic [127:0] rd_key
);

    localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS);

    // FIPS-197 S-box, entry 0 leftmost.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic {IDLE, EXPAND} state_t;

    state_t         state;
    state_t         state_nxt;
    logic           accept;
    logic           last;
    logic [7:0]     rcon;
    logic [7:0]     rcon_nxt;
    logic [127:0]   key_nxt;
    logic [127:0]   rk_file [0:10];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        last      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = EXPAND;
                end
            end
            EXPAND: begin
                if (rk_index == LAST_IDX) begin
                    last      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy     = (state == EXPAND);
    assign rk_valid = busy;
    assign done     = busy && (rk_index == LAST_IDX);

    // Next round key from the key currently presented.
    always_comb begin
        logic [31:0] w0, w1, w2, w3, rot, t, n0, n1, n2, n3;
        w0  = round_key[127:96];
        w1  = round_key[95:64];
        w2  = round_key[63:32];
        w3  = round_key[31:0];
        rot = {w3[23:0], w3[31:24]};
        t   = {SBOX[rot[31:24]], SBOX[rot[23:16]], SBOX[rot[15:8]], SBOX[rot[7:0]]}
              ^ {rcon, 24'h0};
        n0  = w0 ^ t;
        n1  = w1 ^ n0;
        n2  = w2 ^ n1;
        n3  = w3 ^ n2;
        key_nxt  = {n0, n1, n2, n3};
        rcon_nxt = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
    end

    // The file entry for a round is written at the end of the cycle that
    // presents it; round_key/rk_index freeze on the last round.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            round_key <= '0;
            rk_index  <= '0;
            rcon      <= 8'h01;
            for (int i = 0; i <= 10; i++) rk_file[i] <= '0;
        end else if (accept) begin
            round_key <= key;
            rk_index  <= '0;
            rcon      <= 8'h01;
        end else if (busy) begin
            rk_file[rk_index] <= round_key;
            if (!last) begin
                round_key <= key_nxt;
                rk_index  <= rk_index + 4'd1;
                rcon      <= rcon_nxt;
            end
        end
    end

    assign rd_key = (rd_index <= LAST_IDX) ? rk_file[rd_index] : '0;

endmodule

// File: tb/tb_aes128_key_expand.sv
module tb_aes128_key_expand;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start;
    logic [127:0] key;
    logic         busy;
    logic         rk_valid;
    logic [3:0]   rk_index;
    logic [127:0] round_key;
    logic         done;
    logic [3:0]   rd_index;
    logic [127:0] rd_key;

    int total = 0;
    int bad   = 0;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_RK [0:10] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };
    localparam logic [127:0] ZERO_K1  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] ZERO_K10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    aes128_key_expand #(.NUM_ROUNDS(10)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .key       (key),
        .busy      (busy),
        .rk_valid  (rk_valid),
        .rk_index  (rk_index),
        .round_key (round_key),
        .done      (done),
        .rd_index  (rd_index),
        .rd_key    (rd_key)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Full FIPS expansion from an idle DUT. Optionally pulses ignored starts
    // (key=0) while rk_index=4 and on the done cycle.
    task automatic run_fips(input bit ignore_starts);
        @(negedge clk);
        key   = FIPS_KEY;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        key   = '0;
        chk("r0_valid", 128'(rk_valid), 128'(1));
        chk("r0_busy",  128'(busy),     128'(1));
        chk("r0_index", 128'(rk_index), 128'(0));
        chk("r0_key",   round_key,      FIPS_RK[0]);
        chk("r0_done",  128'(done),     128'(0));
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            start = 1'b0;
            chk($sformatf("r%0d_valid", n), 128'(rk_valid), 128'(1));
            chk($sformatf("r%0d_index", n), 128'(rk_index), 128'(n));
            chk($sformatf("r%0d_key", n),   round_key,      FIPS_RK[n]);
            chk($sformatf("r%0d_done", n),  128'(done),     128'(n == 10));
            if (ignore_starts && (n == 4 || n == 10)) begin
                key   = '0;
                start = 1'b1;
            end
        end
        @(negedge clk);
        start = 1'b0;
        chk("end_busy",  128'(busy),     128'(0));
        chk("end_valid", 128'(rk_valid), 128'(0));
        chk("end_done",  128'(done),     128'(0));
        chk("end_key",   round_key,      FIPS_RK[10]);
        chk("end_index", 128'(rk_index), 128'(10));
    endtask

    initial begin
        reset_n  = 1'b0;
        start    = 1'b0;
        key      = '0;
        rd_index = '0;

        // Reset then idle
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_busy",  128'(busy),     128'(0));
        chk("rst_valid", 128'(rk_valid), 128'(0));
        chk("rst_done",  128'(done),     128'(0));
        chk("rst_key",   round_key,      '0);
        for (int i = 0; i < 16; i++) begin
            rd_index = 4'(i);
            #1 chk($sformatf("rst_file%0d", i), rd_key, '0);
        end

        // FIPS vector, file contents afterwards
        run_fips(1'b0);
        for (int i = 0; i < 16; i++) begin
            rd_index = 4'(i);
            #1 chk($sformatf("fips_file%0d", i), rd_key, (i <= 10) ? FIPS_RK[i] : '0);
        end

        // Ignored starts during expansion and on the done cycle
        run_fips(1'b1);

        // Back-to-back: zero key on the first busy=0 cycle
        key   = '0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("z_r0_index", 128'(rk_index), 128'(0));
        chk("z_r0_key",   round_key,      '0);
        rd_index = 4'd1;
        #1 chk("z_file1_old", rd_key, FIPS_RK[1]);
        @(negedge clk);
        chk("z_r1_index", 128'(rk_index), 128'(1));
        chk("z_r1_key",   round_key,      ZERO_K1);
        repeat (9) @(negedge clk);
        chk("z_r10_key",  round_key,      ZERO_K10);
        chk("z_r10_done", 128'(done),     128'(1));
        @(negedge clk);
        chk("z_end_busy", 128'(busy),     128'(0));
        rd_index = 4'd0;
        #1 chk("z_file0",  rd_key, '0);
        rd_index = 4'd1;
        #1 chk("z_file1",  rd_key, ZERO_K1);
        rd_index = 4'd10;
        #1 chk("z_file10", rd_key, ZERO_K10);
        rd_index = 4'd11;
        #1 chk("z_file11", rd_key, '0);

        // Mid-operation reset at rk_index=5
        @(negedge clk);
        key   = FIPS_KEY;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk("mr_index_pre", 128'(rk_index), 128'(5));
        reset_n = 1'b0;
        #1;
        chk("mr_busy",  128'(busy),      128'(0));
        chk("mr_valid", 128'(rk_valid),  128'(0));
        chk("mr_index", 128'(rk_index),  128'(0));
        chk("mr_key",   round_key,       '0);
        chk("mr_done",  128'(done),      128'(0));
        rd_index = 4'd3;
        #1 chk("mr_file3", rd_key, '0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("mr_hold_done", 128'(done), 128'(0));
        end
        reset_n = 1'b1;
        run_fips(1'b0);
        rd_index = 4'd10;
        #1 chk("mr_file10", rd_key, FIPS_RK[10]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
